// File: rtl/pcie_defs.sv
`default_nettype none
// ============================================================================
// Module      : pcie_defs (package)
// Description : Shared constants for the 8b/10b receive path: K28.5 comma
//               patterns (both running disparities), default alignment
//               thresholds and the comma aligner state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pcie_defs;

    // K28.5, first transmitted bit in position 9
    localparam logic [9:0] c_k28_5_rdn = 10'b0011111010;
    localparam logic [9:0] c_k28_5_rdp = 10'b1100000101;

    localparam int c_comas_lock_def = 3;
    localparam int c_err_unlock_def = 4;

    // Consecutive comma-less word boundaries tolerated while aligning
    localparam logic [7:0] c_timeout_max = 8'd255;

    // Phase counter value on the last bit of a word
    localparam logic [3:0] c_phase_last = 4'd9;

    typedef enum logic [1:0] {
        BUSCAR       = 2'd0,
        ALINEANDO    = 2'd1,
        SINCRONIZADO = 2'd2
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/detector_coma.sv
`default_nettype none
// ============================================================================
// Module      : detector_coma
// Description : Combinational K28.5 comma detector for a 10-bit code group.
// Ports       : code - 10-bit code group, first received bit in code[9]
//               coma - high when code is K28.5 of either disparity
// Revision    : 1.0 - initial release
// ============================================================================
module detector_coma
    import pcie_defs::*;
(
    input  logic [9:0] code,
    output logic       coma
);

    assign coma = (code == c_k28_5_rdn) || (code == c_k28_5_rdp);

endmodule
`default_nettype wire

// File: rtl/alineador_coma.sv
`default_nettype none
// ============================================================================
// Module      : alineador_coma
// Description : Serial-to-parallel comma aligner for an 8b/10b bit stream.
//               Searches for K28.5, aligns word boundaries to it, declares
//               lock after COMAS_LOCK aligned commas and drops lock after
//               ERR_UNLOCK consecutive misaligned commas.
// Ports       : clk          - one received bit per rising edge
//               rst          - asynchronous active-low reset
//               enb          - enable; low freezes all state, valid forced 0
//               serialIn     - received serial bit
//               dataOut      - aligned 10-bit word, first bit in dataOut[9]
//               valid        - one-cycle pulse per new word on dataOut
//               esComa       - dataOut is K28.5 (qualified by valid)
//               sincronizado - high while locked
//               errSync      - one-cycle pulse on loss of lock
// Revision    : 1.0 - initial release
// ============================================================================
module alineador_coma
    import pcie_defs::*;
#(
    parameter int COMAS_LOCK = c_comas_lock_def,
    parameter int ERR_UNLOCK = c_err_unlock_def
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       serialIn,
    output logic [9:0] dataOut,
    output logic       valid,
    output logic       esComa,
    output logic       sincronizado,
    output logic       errSync
);

    localparam int CW = $clog2(COMAS_LOCK + 1);
    localparam int EW = $clog2(ERR_UNLOCK + 1);
    localparam logic [CW-1:0] c_lock   = CW'(COMAS_LOCK);
    localparam logic [EW-1:0] c_unlock = EW'(ERR_UNLOCK);

    estado_t       r_state, w_state_next;
    logic [9:0]    r_shreg;
    logic [9:0]    w_shreg_next;
    logic [3:0]    r_phase, w_phase_next;
    logic [CW-1:0] r_comas, w_comas_next;
    logic [EW-1:0] r_errs, w_errs_next;
    logic [7:0]    r_timeout, w_timeout_next;
    logic          r_valid;
    logic          w_coma, w_boundary, w_load, w_err_pulse;

    // Comma detection looks at the window including the bit arriving now,
    // so a word is captured on the same edge that delivers its last bit.
    assign w_shreg_next = {r_shreg[8:0], serialIn};
    assign w_boundary   = (r_phase == c_phase_last);

    detector_coma u_detector_coma (
        .code (w_shreg_next),
        .coma (w_coma)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= BUSCAR;
        end else if (enb) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_phase_next   = w_boundary ? 4'd0 : r_phase + 4'd1;
        w_comas_next   = r_comas;
        w_errs_next    = r_errs;
        w_timeout_next = r_timeout;
        w_load         = 1'b0;
        w_err_pulse    = 1'b0;
        case (r_state)
            BUSCAR: begin
                // The found comma becomes the first aligned word
                if (w_coma) begin
                    w_load         = 1'b1;
                    w_phase_next   = 4'd0;
                    w_comas_next   = CW'(1);
                    w_errs_next    = '0;
                    w_timeout_next = '0;
                    w_state_next   = (COMAS_LOCK <= 1) ? SINCRONIZADO : ALINEANDO;
                end
            end
            ALINEANDO: begin
                if (w_coma) begin
                    // An off-boundary comma is taken as the new boundary
                    w_load         = 1'b1;
                    w_phase_next   = 4'd0;
                    w_timeout_next = '0;
                    if (w_boundary) begin
                        if (r_comas != c_lock) begin
                            w_comas_next = r_comas + CW'(1);
                        end
                        if (w_comas_next == c_lock) begin
                            w_state_next = SINCRONIZADO;
                            w_errs_next  = '0;
                        end
                    end else begin
                        w_comas_next = CW'(1);
                    end
                end else if (w_boundary) begin
                    w_load = 1'b1;
                    if (r_timeout != c_timeout_max) begin
                        w_timeout_next = r_timeout + 8'd1;
                    end
                    if (w_timeout_next == c_timeout_max) begin
                        w_state_next   = BUSCAR;
                        w_comas_next   = '0;
                        w_timeout_next = '0;
                    end
                end
            end
            SINCRONIZADO: begin
                if (w_boundary) begin
                    w_load = 1'b1;
                    if (w_coma) begin
                        w_errs_next = '0;
                    end
                end else if (w_coma) begin
                    // Lock is kept: misaligned commas are only counted
                    if (r_errs != c_unlock) begin
                        w_errs_next = r_errs + EW'(1);
                    end
                    if (w_errs_next == c_unlock) begin
                        w_state_next   = BUSCAR;
                        w_err_pulse    = 1'b1;
                        w_comas_next   = '0;
                        w_errs_next    = '0;
                        w_timeout_next = '0;
                    end
                end
            end
            default: begin
                w_state_next = BUSCAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg   <= '0;
            r_phase   <= '0;
            r_comas   <= '0;
            r_errs    <= '0;
            r_timeout <= '0;
            r_valid   <= 1'b0;
            dataOut   <= '0;
            esComa    <= 1'b0;
            errSync   <= 1'b0;
        end else if (enb) begin
            r_shreg   <= w_shreg_next;
            r_phase   <= w_phase_next;
            r_comas   <= w_comas_next;
            r_errs    <= w_errs_next;
            r_timeout <= w_timeout_next;
            r_valid   <= w_load;
            errSync   <= w_err_pulse;
            if (w_load) begin
                dataOut <= w_shreg_next;
                esComa  <= w_coma;
            end
        end
    end

    // A pulse pending when enb drops reappears once enb returns high
    assign valid        = r_valid & enb;
    assign sincronizado = (r_state == SINCRONIZADO);

endmodule
`default_nettype wire

// File: tb/tb_alineador_coma.sv
`default_nettype none
// ============================================================================
// Module      : tb_alineador_coma
// Description : Self-checking bench for alineador_coma. A bit-level reference
//               model tracks word boundaries as an absolute bit index and is
//               compared against the DUT every cycle; directed scenarios add
//               checks against the transmitted words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alineador_coma;

    localparam int         LOCK_N   = 3;
    localparam int         UNLOCK_N = 4;
    localparam logic [9:0] K_NEG    = 10'b0011111010;
    localparam logic [9:0] K_POS    = 10'b1100000101;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       serialIn;
    logic [9:0] dataOut;
    logic       valid;
    logic       esComa;
    logic       sincronizado;
    logic       errSync;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_errp   = 0;

    logic [9:0] data_words [4];

    // Reference model state
    int         m_state;   // 0 search, 1 aligning, 2 locked
    logic [9:0] m_win;
    int         m_n;
    int         m_anchor;
    int         m_cnt;
    int         m_err;
    int         m_miss;
    logic       m_valid;
    logic [9:0] m_data;
    logic       m_coma;
    logic       m_errs;

    alineador_coma #(
        .COMAS_LOCK (LOCK_N),
        .ERR_UNLOCK (UNLOCK_N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .serialIn     (serialIn),
        .dataOut      (dataOut),
        .valid        (valid),
        .esComa       (esComa),
        .sincronizado (sincronizado),
        .errSync      (errSync)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_win = '0; m_n = 0; m_anchor = 0;
        m_cnt = 0; m_err = 0; m_miss = 0;
        m_valid = 1'b0; m_data = '0; m_coma = 1'b0; m_errs = 1'b0;
    endfunction

    // One received bit, expressed with absolute bit positions: a word ends
    // every 10 bits after the last comma the aligner anchored to.
    function automatic void model_step(input logic b, input logic e);
        logic c, bnd, emit;
        if (!e) return;
        m_win  = {m_win[8:0], b};
        c      = (m_win == K_NEG) || (m_win == K_POS);
        bnd    = (m_state != 0) && (((m_n - m_anchor) % 10) == 0);
        emit   = 1'b0;
        m_errs = 1'b0;
        case (m_state)
            0: if (c) begin
                m_anchor = m_n; m_cnt = 1; m_err = 0; m_miss = 0;
                emit = 1'b1; m_state = 1;
            end
            1: if (c) begin
                emit = 1'b1; m_miss = 0;
                if (bnd) begin
                    m_cnt++;
                    if (m_cnt >= LOCK_N) begin m_state = 2; m_err = 0; end
                end else begin
                    m_anchor = m_n; m_cnt = 1;
                end
            end else if (bnd) begin
                emit = 1'b1; m_miss++;
                if (m_miss >= 255) begin m_state = 0; m_cnt = 0; m_miss = 0; end
            end
            default: if (bnd) begin
                emit = 1'b1;
                if (c) m_err = 0;
            end else if (c) begin
                m_err++;
                if (m_err >= UNLOCK_N) begin
                    m_state = 0; m_errs = 1'b1; m_err = 0; m_cnt = 0; m_miss = 0;
                end
            end
        endcase
        m_valid = emit;
        if (emit) begin m_data = m_win; m_coma = c; end
        m_n++;
    endfunction

    task automatic drive_bit(input logic b, input logic e);
        @(negedge clk);
        serialIn = b;
        enb      = e;
        @(posedge clk);
        model_step(b, e);
        #1;
        chk_eq("valid",   {31'd0, valid},        {31'd0, m_valid & e});
        chk_eq("sync",    {31'd0, sincronizado}, {31'd0, (m_state == 2)});
        chk_eq("errSync", {31'd0, errSync},      {31'd0, m_errs});
        chk_eq("dataOut", {22'd0, dataOut},      {22'd0, m_data});
        chk_eq("esComa",  {31'd0, esComa},       {31'd0, m_coma});
        if (valid === 1'b1) n_valid++;
        if (errSync === 1'b1 && e) n_errp++;
    endtask

    task automatic send_bits(input logic [9:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) drive_bit(bits[i], 1'b1);
    endtask

    task automatic send_word(input logic [9:0] w);
        send_bits(w, 10);
    endtask

    // Enable toggles randomly; a bit is only consumed on an enabled cycle
    task automatic send_rand(input logic [9:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            logic e;
            do begin
                e = ($urandom_range(0, 7) != 0);
                drive_bit(e ? bits[i] : logic'($urandom_range(0, 1)), e);
            end while (!e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; enb = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [9:0] w;
        int         nv;
        data_words[0] = 10'b1010101010;
        data_words[1] = 10'b0101010101;
        data_words[2] = 10'b1001110100;
        data_words[3] = 10'b0110001011;
        rst = 1'b0; enb = 1'b0; serialIn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_data",  {22'd0, dataOut},      32'd0);
        chk_eq("rst_valid", {31'd0, valid},        32'd0);
        chk_eq("rst_coma",  {31'd0, esComa},       32'd0);
        chk_eq("rst_sync",  {31'd0, sincronizado}, 32'd0);
        chk_eq("rst_err",   {31'd0, errSync},      32'd0);
        @(negedge clk);
        rst = 1'b1;

        // First comma and following data, one word every 10 bits
        send_word(10'b0000000000);
        send_word(K_NEG);
        chk_eq("s1_valid", {31'd0, valid}, 32'd1);
        chk_eq("s1_coma",  {31'd0, esComa}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            send_word(data_words[i]);
            chk_eq("s1_dvalid", {31'd0, valid}, 32'd1);
            chk_eq("s1_data",   {22'd0, dataOut}, {22'd0, data_words[i]});
        end

        // Lock on the third aligned comma
        do_reset();
        send_word(K_NEG);
        send_word(K_POS);
        chk_eq("s2_sync2", {31'd0, sincronizado}, 32'd0);
        send_word(K_NEG);
        chk_eq("s2_sync3", {31'd0, sincronizado}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_word(data_words[i]);
            chk_eq("s2_data", {22'd0, dataOut}, {22'd0, data_words[i]});
        end

        // Four commas shifted by 3 bits drop lock
        n_errp = 0;
        send_bits(10'b101, 3);
        for (int i = 0; i < 4; i++) send_word(K_NEG);
        chk_eq("s3_errp",  {31'd0, errSync}, 32'd1);
        chk_eq("s3_sync",  {31'd0, sincronizado}, 32'd0);
        nv = n_valid;
        for (int i = 0; i < 3; i++) send_word(data_words[i]);
        chk_eq("s3_novalid", nv, n_valid);
        chk_eq("s3_npulse",  n_errp, 32'd1);
        send_word(K_NEG);
        chk_eq("s3_recoma", {31'd0, valid & esComa}, 32'd1);

        // Relock, then misaligned commas cleared by an aligned one
        send_word(K_NEG);
        send_word(K_NEG);
        chk_eq("s4_lock", {31'd0, sincronizado}, 32'd1);
        send_bits(10'b101, 3);
        for (int i = 0; i < 3; i++) send_word(K_NEG);
        send_bits(10'b1010101, 7);
        send_word(K_NEG);
        chk_eq("s4_bcoma", {31'd0, valid & esComa}, 32'd1);
        send_bits(10'b101, 3);
        for (int i = 0; i < 3; i++) send_word(K_NEG);
        chk_eq("s4_still", {31'd0, sincronizado}, 32'd1);
        send_bits(10'b1010101, 7);
        send_word(data_words[0]);
        chk_eq("s4_data", {22'd0, dataOut}, {22'd0, data_words[0]});

        // Asynchronous reset in the middle of a word
        send_bits(10'b10101, 5);
        #2;
        rst = 1'b0; enb = 1'b0;
        #1;
        chk_eq("s5_data",  {22'd0, dataOut},      32'd0);
        chk_eq("s5_valid", {31'd0, valid},        32'd0);
        chk_eq("s5_coma",  {31'd0, esComa},       32'd0);
        chk_eq("s5_sync",  {31'd0, sincronizado}, 32'd0);
        chk_eq("s5_err",   {31'd0, errSync},      32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_word(K_NEG);
        send_word(K_NEG);
        chk_eq("s5_nolock", {31'd0, sincronizado}, 32'd0);
        send_word(K_NEG);
        chk_eq("s5_relock", {31'd0, sincronizado}, 32'd1);

        // Enable low for 7 clocks mid-word
        w = data_words[2];
        send_bits(w[9:6], 4);
        for (int i = 0; i < 7; i++) drive_bit(logic'($urandom_range(0, 1)), 1'b0);
        send_bits(w[5:0], 6);
        chk_eq("s6_valid", {31'd0, valid}, 32'd1);
        chk_eq("s6_data",  {22'd0, dataOut}, {22'd0, w});
        send_word(data_words[3]);
        chk_eq("s6_next",  {22'd0, dataOut}, {22'd0, data_words[3]});

        // Alignment timeout after 255 comma-less boundaries
        do_reset();
        send_word(K_NEG);
        for (int i = 0; i < 254; i++) send_word(data_words[i % 4]);
        chk_eq("s7_v254", {31'd0, valid}, 32'd1);
        send_word(data_words[2]);
        chk_eq("s7_v255", {31'd0, valid}, 32'd1);
        nv = n_valid;
        send_word(data_words[3]);
        chk_eq("s7_gone", nv, n_valid);

        // Random mix of commas, data and bit slips
        do_reset();
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: send_rand(10'($urandom), 10);
                3:       send_rand(($urandom_range(0, 1) != 0) ? K_NEG : K_POS, 10);
                4:       send_rand(10'($urandom), $urandom_range(1, 9));
                default: send_rand(K_NEG, 10);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
